toggle_pulse_gen: RTL and testbench

Debounced button-to-toggle front end for the T flip-flop stage. It synchronises a raw, bouncy `btn_in` and qualifies it with a debounce counter. Each clean press produces exactly one single-cycle `pulse_out` that drives the T flip-flop's `in_a` directly, plus a debounced level for status use.

---
 rtl/toggle_pulse_gen_pkg.sv | 21 ++
 rtl/toggle_pulse_gen_sync_2ff.sv | 29 ++
 rtl/toggle_pulse_gen.sv | 158 +++++++++++++++
 tb/tb_toggle_pulse_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pulse_gen_pkg.sv
// Shared definitions for the button-to-toggle front end: FSM state encodings
// and default parameter values.
package toggle_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM_HI = 2'd1,
    HELD   = 2'd2,
    ARM_LO = 2'd3
  } state_e;

  localparam int DEB_CYCLES_DEF    = 4;
  localparam int REPEAT_CYCLES_DEF = 8;
  localparam int CNT_W_DEF         = 8;

  // True when a value does not fit in an unsigned counter of the given width.
  function automatic bit exceeds_width(input int value, input int width);
    return (64'(value) >= (64'd1 << width));
  endfunction

endpackage

// File: rtl/toggle_pulse_gen_sync_2ff.sv
// Generic two-flop synchroniser for one asynchronous bit; q lags d by two edges.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/toggle_pulse_gen.sv
// Debounced button to single-cycle toggle pulse; pulse and level change DEB_CYCLES+2 edges after first high sample.
// Optional auto-repeat while held is enabled by defining TOGGLE_AUTO_REPEAT_EN.
module toggle_pulse_gen
  import toggle_pulse_gen_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_out,
  output logic btn_level
);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("toggle_pulse_gen: DEB_CYCLES must be at least 1");
  end
  if (exceeds_width(DEB_CYCLES - 1, CNT_W)) begin : g_bad_cnt_deb
    $error("toggle_pulse_gen: CNT_W too narrow for DEB_CYCLES");
  end
  if (REPEAT_CYCLES < 1 || exceeds_width(REPEAT_CYCLES - 1, CNT_W)) begin : g_bad_cnt_rep
    $error("toggle_pulse_gen: REPEAT_CYCLES must be >= 1 and fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic btn_sync;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

`ifdef TOGGLE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_q, rep_d;
`endif

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_sync)
  );

  // State register: reset overrides any transition or pulse in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
`ifdef TOGGLE_AUTO_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
`ifdef TOGGLE_AUTO_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef TOGGLE_AUTO_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = ARM_HI;
          cnt_d   = '0;
        end
      end
      ARM_HI: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
`ifdef TOGGLE_AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_d = ARM_LO;
          cnt_d   = '0;
`ifdef TOGGLE_AUTO_REPEAT_EN
          rep_d   = '0;
        end else if (rep_q == REP_LAST) begin
          rep_d = '0;
        end else begin
          rep_d = rep_q + CNT_W'(1);
`endif
        end
      end
      ARM_LO: begin
        // A bounce back high resumes HELD quietly; the repeat period restarts.
        if (btn_sync) begin
          state_d = HELD;
`ifdef TOGGLE_AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pulse_d = 1'b0;
    level_d = level_q;
    case (state_q)
      ARM_HI: begin
        if (btn_sync && (cnt_q == DEB_LAST)) begin
          pulse_d = 1'b1;
          level_d = 1'b1;
        end
      end
      HELD: begin
`ifdef TOGGLE_AUTO_REPEAT_EN
        if (btn_sync && (rep_q == REP_LAST)) begin
          pulse_d = 1'b1;
        end
`endif
      end
      ARM_LO: begin
        if (!btn_sync && (cnt_q == DEB_LAST)) begin
          level_d = 1'b0;
        end
      end
      default: begin
        pulse_d = 1'b0;
      end
    endcase
  end

  assign pulse_out = pulse_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Self-checking bench for toggle_pulse_gen with DEB_CYCLES=4, REPEAT_CYCLES=8, 20 ns clock.
module tb_toggle_pulse_gen;
  import toggle_pulse_gen_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic pulse_out;
  logic btn_level;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_q[$];

  always #10 clk = ~clk;

  toggle_pulse_gen #(
    .DEB_CYCLES    (4),
    .REPEAT_CYCLES (8),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .pulse_out (pulse_out),
    .btn_level (btn_level)
  );

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    btn_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (pulse_out !== 1'b0 || btn_level !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs edge %0d: pulse=%b level=%b, want 0 0", i, pulse_out, btn_level);
      end
      n_vec++;
      if (dut.state_q !== IDLE) begin
        n_err++;
        $display("FAIL reset_state edge %0d: state=%0d, want %0d", i, dut.state_q, IDLE);
      end
    end
    rst = 1'b0;
  endtask

  // Press held 20 cycles from relative edge 0: pulse after edge 6, level high from edge 6.
  task automatic test_press;
    int  base;
    logic exp_p;
    base = cyc + 1;
    exp_q.push_back(base + 6);
`ifdef TOGGLE_AUTO_REPEAT_EN
    exp_q.push_back(base + 14);
`endif
    for (int i = 0; i < 20; i++) begin
      btn_in = 1'b1;
      tick();
      exp_p = (exp_q.size() > 0 && exp_q[0] == cyc);
      if (exp_p) void'(exp_q.pop_front());
      n_vec++;
      if (pulse_out !== exp_p) begin
        n_err++;
        $display("FAIL press_pulse edge %0d: got %b want %b", i, pulse_out, exp_p);
      end
      n_vec++;
      if (btn_level !== (i >= 6)) begin
        n_err++;
        $display("FAIL press_level edge %0d: got %b want %b", i, btn_level, (i >= 6));
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL press_missing: %0d pulses not seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Release with bounce: low 2, high 1, then low from r=3; level falls at edge 9, no pulses.
  task automatic test_release_bounce;
    for (int i = 0; i < 13; i++) begin
      btn_in = (i == 2);
      tick();
      n_vec++;
      if (pulse_out !== 1'b0) begin
        n_err++;
        $display("FAIL release_pulse edge %0d: got %b want 0", i, pulse_out);
      end
      n_vec++;
      if (btn_level !== (i < 9)) begin
        n_err++;
        $display("FAIL release_level edge %0d: got %b want %b", i, btn_level, (i < 9));
      end
    end
  endtask

  // Only four consecutive high samples: rejected as a glitch.
  task automatic test_glitch;
    for (int i = 0; i < 12; i++) begin
      btn_in = (i < 4);
      tick();
      n_vec++;
      if (pulse_out !== 1'b0 || btn_level !== 1'b0) begin
        n_err++;
        $display("FAIL glitch edge %0d: pulse=%b level=%b, want 0 0", i, pulse_out, btn_level);
      end
    end
    n_vec++;
    if (dut.state_q !== IDLE) begin
      n_err++;
      $display("FAIL glitch_state: state=%0d want %0d", dut.state_q, IDLE);
    end
  endtask

  // Reset at edge 5 while arming; first post-reset sample is edge 6, so the pulse lands at edge 12.
  task automatic test_reset_mid;
    int  base;
    logic exp_p;
    base = cyc + 1;
    exp_q.push_back(base + 12);
    for (int i = 0; i < 30; i++) begin
      btn_in = (i < 16);
      rst    = (i == 5);
      tick();
      if (i == 5) begin
        n_vec++;
        if (dut.state_q !== IDLE || dut.cnt_q !== 8'd0) begin
          n_err++;
          $display("FAIL rst_mid_state: state=%0d cnt=%0d, want %0d 0", dut.state_q, dut.cnt_q, IDLE);
        end
      end
      exp_p = (exp_q.size() > 0 && exp_q[0] == cyc);
      if (exp_p) void'(exp_q.pop_front());
      n_vec++;
      if (pulse_out !== exp_p) begin
        n_err++;
        $display("FAIL rst_mid_pulse edge %0d: got %b want %b", i, pulse_out, exp_p);
      end
      n_vec++;
      if (btn_level !== (i >= 12 && i < 22)) begin
        n_err++;
        $display("FAIL rst_mid_level edge %0d: got %b want %b", i, btn_level, (i >= 12 && i < 22));
      end
    end
    rst = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid_missing: %0d pulses not seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Held 32 cycles: repeat pulses every 8 cycles when enabled, a single pulse otherwise.
  task automatic test_auto_repeat;
    int  base;
    logic exp_p;
    base = cyc + 1;
    exp_q.push_back(base + 6);
`ifdef TOGGLE_AUTO_REPEAT_EN
    exp_q.push_back(base + 14);
    exp_q.push_back(base + 22);
    exp_q.push_back(base + 30);
`endif
    for (int i = 0; i < 40; i++) begin
      btn_in = (i < 32);
      tick();
      exp_p = (exp_q.size() > 0 && exp_q[0] == cyc);
      if (exp_p) void'(exp_q.pop_front());
      n_vec++;
      if (pulse_out !== exp_p) begin
        n_err++;
        $display("FAIL repeat_pulse edge %0d: got %b want %b", i, pulse_out, exp_p);
      end
      n_vec++;
      if (btn_level !== (i >= 6 && i < 38)) begin
        n_err++;
        $display("FAIL repeat_level edge %0d: got %b want %b", i, btn_level, (i >= 6 && i < 38));
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL repeat_missing: %0d pulses not seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    #1;
    test_reset();
    test_press();
    test_release_bounce();
    test_glitch();
    test_reset_mid();
    test_auto_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
